// File: rtl/gate_stream_unit.sv
// Registered valid/ready stage applying one of eight bitwise gate functions,
// either per beat (pairwise) or reduced across a burst of beats (fold).
module gate_stream_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned BW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [BW-1:0]    out_beats,
  output logic             out_err
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    FOLD = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [BW-1:0]    count, count_d;
  logic [2:0]       op_q, op_d;
  logic             load_out;
  logic [WIDTH-1:0] y_d;
  logic [BW-1:0]    beats_d;
  logic             err_d;
  logic             accept;
  logic [WIDTH-1:0] fold_y;
  logic [BW-1:0]    count_inc;

  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = x;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOT:  r = ~x;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

  // A new result may only be written when the output slot is free or draining.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign fold_y    = gate_f(op_q, acc, in_a);
  assign count_inc = count + BW'(1);

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    count_d  = count;
    op_d     = op_q;
    load_out = 1'b0;
    y_d      = out_y;
    beats_d  = out_beats;
    err_d    = out_err;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!in_mode) begin
            load_out = 1'b1;
            y_d      = gate_f(in_op, in_a, in_b);
            beats_d  = BW'(1);
            err_d    = 1'b0;
          end else begin
            op_d    = in_op;
            acc_d   = in_a;
            count_d = BW'(1);
            if (in_last) begin
              load_out = 1'b1;
              y_d      = in_a;
              beats_d  = BW'(1);
              err_d    = 1'b0;
            end else begin
              state_d = FOLD;
            end
          end
        end
        FOLD: begin
          acc_d   = fold_y;
          count_d = count_inc;
          // Close the burst on the marked last beat or when the cap is hit.
          if (in_last || (count_inc == BW'(MAX_BEATS))) begin
            load_out = 1'b1;
            y_d      = fold_y;
            beats_d  = count_inc;
            err_d    = !in_last;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      op_q      <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_beats <= '0;
      out_err   <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      count <= count_d;
      op_q  <= op_d;
      if (load_out) begin
        out_valid <= 1'b1;
        out_y     <= y_d;
        out_beats <= beats_d;
        out_err   <= err_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gate_stream_unit.sv
// Bench for gate_stream_unit: directed literal cases plus randomized traffic
// checked every cycle against a burst-level reference model.
module tb_gate_stream_unit;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned BW        = $clog2(MAX_BEATS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             in_mode = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_y;
  logic [BW-1:0]    out_beats;
  logic             out_err;

  gate_stream_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_beats(out_beats), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    int               beats;
    bit               err;
  } res_t;

  int n_checks = 0;
  int n_fail   = 0;

  res_t             exp_q[$];
  logic [WIDTH-1:0] burst[$];
  bit               burst_open = 0;
  logic [2:0]       burst_op = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~x;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return x ^ y;
      3'd6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // Reference: collect burst operands, reduce them left to right when the burst closes.
  task automatic model_accept();
    res_t r;
    logic [WIDTH-1:0] acc;
    if (!burst_open) begin
      if (!in_mode) begin
        r.y = ref_gate(in_op, in_a, in_b); r.beats = 1; r.err = 0;
        exp_q.push_back(r);
      end else begin
        burst_op = in_op;
        burst.delete();
        burst.push_back(in_a);
        if (in_last) begin
          r.y = in_a; r.beats = 1; r.err = 0;
          exp_q.push_back(r);
        end else begin
          burst_open = 1;
        end
      end
    end else begin
      burst.push_back(in_a);
      if (in_last || burst.size() == MAX_BEATS) begin
        acc = burst[0];
        for (int i = 1; i < burst.size(); i++) acc = ref_gate(burst_op, acc, burst[i]);
        r.y = acc; r.beats = burst.size(); r.err = !in_last;
        exp_q.push_back(r);
        burst_open = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      burst.delete();
      burst_open = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_y", 32'(out_y), 32'(exp_q[0].y));
        chk("out_beats", 32'(out_beats), 32'(exp_q[0].beats));
        chk("out_err", 32'(out_err), 32'(exp_q[0].err));
      end
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) model_accept();
    end
  end

  // Starts and ends at posedge+1; waits a bounded number of cycles for acceptance.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic mode, input logic last);
    in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input string name, input logic [7:0] y, input int beats,
                            input logic err);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_y"}, 32'(out_y), 32'(y));
    chk({name, "_beats"}, 32'(out_beats), 32'(beats));
    chk({name, "_err"}, 32'(out_err), 32'(err));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_beats", 32'(out_beats), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Pairwise with a=F0 b=3C
    send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0); expect_now("pw_and", 8'h30, 1, 1'b0);
    send(8'hF0, 8'h3C, 3'd5, 1'b0, 1'b0); expect_now("pw_xor", 8'hCC, 1, 1'b0);
    send(8'hF0, 8'h3C, 3'd3, 1'b0, 1'b0); expect_now("pw_nand", 8'hCF, 1, 1'b0);
    send(8'hF0, 8'h3C, 3'd2, 1'b0, 1'b0); expect_now("pw_not", 8'h0F, 1, 1'b0);
    send(8'hF0, 8'h3C, 3'd7, 1'b0, 1'b0); expect_now("pw_buf", 8'hF0, 1, 1'b0);

    // Backpressure: first result held, second beat stalls until release
    out_ready = 1'b0;
    send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
    in_a = 8'hF0; in_b = 8'h3C; in_op = 3'd1; in_mode = 1'b0; in_last = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_y", 32'(out_y), 32'h30);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_y", 32'(out_y), 32'hFC);
    @(posedge clk); #1;

    // Fold OR 01,02,04
    send(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h04, 8'h00, 3'd1, 1'b1, 1'b1);
    expect_now("fold_or", 8'h07, 3, 1'b0);

    // Fold XOR capped at MAX_BEATS, then a fresh burst
    for (int i = 0; i < 4; i++) send(8'h01, 8'h00, 3'd5, 1'b1, 1'b0);
    expect_now("fold_cap", 8'h00, 4, 1'b1);
    send(8'h01, 8'h00, 3'd5, 1'b1, 1'b0);
    send(8'h01, 8'h00, 3'd5, 1'b0, 1'b1);
    expect_now("fold_after_cap", 8'h00, 2, 1'b0);

    // Fold NOT and single-beat fold
    send(8'hAA, 8'h00, 3'd2, 1'b1, 1'b0);
    send(8'hAA, 8'h00, 3'd2, 1'b1, 1'b0);
    send(8'hAA, 8'h00, 3'd2, 1'b1, 1'b1);
    expect_now("fold_not", 8'hAA, 3, 1'b0);
    send(8'h5A, 8'h00, 3'd0, 1'b1, 1'b1);
    expect_now("fold_single", 8'h5A, 1, 1'b0);

    // Reset mid-fold discards the burst
    send(8'h11, 8'h00, 3'd1, 1'b1, 1'b0);
    send(8'h22, 8'h00, 3'd1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0);
    expect_now("post_rst_and", 8'h0F, 1, 1'b0);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_op     = 3'($urandom);
      in_mode   = 1'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
